// File: rtl/image_receiver.sv
// image_receiver: turns a UART byte stream of command/label/pixel frames into an image vector,
// starts one pass per frame, waits for the pass to complete, then answers the host with 0x06.
// Ports: clk, rst_n | rx_data/rx_valid from UART rx | ack from control unit, tx_ready from UART tx |
//        start/train/label/image/busy to control unit | tx_data/tx_valid to UART tx | frame_err pulse.
module image_receiver #(
    parameter int IMG_BYTES = 784,
    parameter int IMG_SZ    = IMG_BYTES << 3,
    parameter int TIMEOUT   = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              ack,
    input  logic              tx_ready,
    output logic              start,
    output logic              train,
    output logic [7:0]        label,
    output logic [IMG_SZ-1:0] image,
    output logic              busy,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    output logic              frame_err
);
    localparam int CW = (IMG_BYTES > 1) ? $clog2(IMG_BYTES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] PIX_LAST  = CW'(IMG_BYTES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [7:0]    CMD_INFER = 8'hA5;
    localparam logic [7:0]    CMD_TRAIN = 8'h5A;
    localparam logic [7:0]    RESP_ACK  = 8'h06;

    typedef enum logic [2:0] {
        IDLE,
        GET_LABEL,
        GET_PIXELS,
        ISSUE,
        WAIT_ACK,
        SEND_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     pix_cnt_q, pix_cnt_d;
    logic [TW-1:0]     to_cnt_q, to_cnt_d;
    logic              train_flag_q, train_flag_d;
    logic [7:0]        label_q, label_d;
    logic [IMG_SZ-1:0] image_q, image_d;
    logic              err_q, err_d;
    logic              err_evt;

    always_comb begin
        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        to_cnt_d     = to_cnt_q;
        train_flag_d = train_flag_q;
        label_d      = label_q;
        image_d      = image_q;
        err_evt      = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_INFER || rx_data == CMD_TRAIN) begin
                        state_d      = GET_LABEL;
                        train_flag_d = (rx_data == CMD_TRAIN);
                        to_cnt_d     = '0;
                    end else begin
                        err_evt = 1'b1;
                    end
                end
            end
            GET_LABEL, GET_PIXELS: begin
                if (rx_valid) begin
                    to_cnt_d = '0;
                    if (state_q == GET_LABEL) begin
                        label_d   = rx_data;
                        pix_cnt_d = '0;
                        state_d   = GET_PIXELS;
                    end else begin
                        image_d[{pix_cnt_q, 3'b000} +: 8] = rx_data;
                        // Counter parks on the last index instead of wrapping.
                        if (pix_cnt_q == PIX_LAST) begin
                            state_d = ISSUE;
                        end else begin
                            pix_cnt_d = pix_cnt_q + 1'b1;
                        end
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    // Host went quiet mid-frame: drop the frame, keep label/image contents.
                    state_d = IDLE;
                    err_evt = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT_ACK;
                err_evt = rx_valid;
            end
            WAIT_ACK: begin
                err_evt = rx_valid;
                if (ack) begin
                    state_d = SEND_RESP;
                end
            end
            SEND_RESP: begin
                err_evt = rx_valid;
                if (tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Back-to-back error events collapse so frame_err stays a single-cycle pulse.
        err_d = err_evt & ~err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pix_cnt_q    <= '0;
            to_cnt_q     <= '0;
            train_flag_q <= 1'b0;
            label_q      <= 8'h00;
            image_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            to_cnt_q     <= to_cnt_d;
            train_flag_q <= train_flag_d;
            label_q      <= label_d;
            image_q      <= image_d;
            err_q        <= err_d;
        end
    end

    assign start     = (state_q == ISSUE);
    assign train     = (state_q == ISSUE) & train_flag_q;
    assign busy      = (state_q != IDLE);
    assign tx_valid  = (state_q == SEND_RESP);
    assign tx_data   = (state_q == SEND_RESP) ? RESP_ACK : 8'h00;
    assign label     = label_q;
    assign image     = image_q;
    assign frame_err = err_q;

endmodule
